// File: rtl/mq_byte_packer_pkg.sv
// Shared constants, error bit indices and packer state encoding for the MQ byte packer.
package mq_pkg;

    localparam int unsigned MQ_BYTE_W    = 8;
    localparam int unsigned MQ_BP_W      = 8;
    localparam int unsigned MQ_CARRY_BIT = 8;

    localparam int unsigned ERR_OVF      = 0;
    localparam int unsigned ERR_BP_SKIP  = 1;
    localparam int unsigned ERR_CARRY_FF = 2;
    localparam int unsigned ERR_W        = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DRAIN  = 2'd3
    } pk_state_e;

    typedef struct packed {
        logic                 last;
        logic [MQ_BYTE_W-1:0] data;
    } fifo_entry_t;

    // Deferred carry applied to a held byte; 0xFF + 1 wraps to 0x00.
    function automatic logic [MQ_BYTE_W-1:0] apply_carry(input logic [MQ_BYTE_W-1:0] b,
                                                         input logic                 c);
        return b + {{(MQ_BYTE_W-1){1'b0}}, c};
    endfunction

endpackage

// File: rtl/mq_byte_packer_if.sv
// Valid/ready byte stream from the packer to the codestream writer.
interface mq_byte_packer_if;
    import mq_pkg::*;

    logic [MQ_BYTE_W-1:0] m_data;
    logic                 m_valid;
    logic                 m_last;
    logic                 m_ready;

    modport master (output m_data, output m_valid, output m_last, input  m_ready);
    modport slave  (input  m_data, input  m_valid, input  m_last, output m_ready);

endinterface

// File: rtl/mq_byte_packer_fifo.sv
// Byte FIFO of {last, data} entries with registered occupancy count.
module mq_byte_fifo
    import mq_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t push_data,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        empty,
    output logic        full,
    output logic        almost_full,
    output logic        overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    logic             rd_en;
    fifo_entry_t      mem_q [DEPTH];

    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == CNT_W'(DEPTH));
        almost_full = (count_q >= CNT_W'(AF_LEVEL));
        rd_en       = pop && !empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        wr_en       = push && (!full || rd_en);
        overflow    = push && full && !rd_en;
        head        = mem_q[rd_ptr_q];

        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mq_byte_packer.sv
// MQ coder byte packer: detects byte events from BP advance, applies deferred carry,
// buffers bytes and emits them on a valid/ready stream with end-of-segment flush.
module mq_byte_packer
    import mq_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        byte_in,
    input  logic [MQ_BP_W-1:0] bp_in,
    input  logic               flush_in,
    mq_byte_packer_if.master   m_if,
    output logic               almost_full,
    output logic               done,
    output logic [ERR_W-1:0]   err,
    output logic [15:0]        byte_cnt
);

    logic [MQ_BP_W-1:0]   bp_prev_q, bp_prev_d;
    logic [MQ_BP_W-1:0]   bp_delta;
    logic                 evt_q, evt_d;
    logic                 evt_skip_q, evt_skip_d;
    logic                 evt_carry_q, evt_carry_d;
    logic [MQ_BYTE_W-1:0] evt_byte_q, evt_byte_d;

    pk_state_e            state_q, state_d;
    logic [MQ_BYTE_W-1:0] hold_q, hold_d;
    logic                 hv_q, hv_d;
    logic                 done_q, done_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [15:0]          byte_cnt_q, byte_cnt_d;

    logic                 take_evt;
    logic                 push;
    fifo_entry_t          push_entry;
    fifo_entry_t          fifo_head;
    logic                 fifo_empty;
    logic                 fifo_full_unused;
    logic                 fifo_overflow;
    logic                 accept;
    logic                 unused_byte_hi;

    assign unused_byte_hi = ^byte_in[15:MQ_CARRY_BIT+1];

    mq_byte_fifo #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (push_entry),
        .pop         (m_if.m_ready),
        .head        (fifo_head),
        .empty       (fifo_empty),
        .full        (fifo_full_unused),
        .almost_full (almost_full),
        .overflow    (fifo_overflow)
    );

    assign m_if.m_valid = !fifo_empty;
    assign m_if.m_data  = fifo_head.data;
    assign m_if.m_last  = fifo_head.last;
    assign accept       = !fifo_empty && m_if.m_ready;

    assign done     = done_q;
    assign err      = err_q;
    assign byte_cnt = byte_cnt_q;

    always_comb begin
        bp_prev_d   = bp_in;
        bp_delta    = bp_in - bp_prev_q;
        evt_d       = (bp_in != bp_prev_q);
        evt_skip_d  = evt_d && (bp_delta != MQ_BP_W'(1));
        evt_carry_d = byte_in[MQ_CARRY_BIT];
        evt_byte_d  = byte_in[MQ_BYTE_W-1:0];

        state_d    = state_q;
        hold_d     = hold_q;
        hv_d       = hv_q;
        done_d     = done_q;
        err_d      = err_q;
        byte_cnt_d = byte_cnt_q + 16'(accept);
        push       = 1'b0;
        push_entry = '0;

        // FLUSH owns the push port, so an event landing there only reloads H.
        take_evt = evt_q && (state_q != ST_FLUSH);
        if (take_evt) begin
            hold_d = evt_byte_q;
            hv_d   = 1'b1;
            if (hv_q) begin
                push       = 1'b1;
                push_entry = '{last: 1'b0, data: apply_carry(hold_q, evt_carry_q)};
                if (evt_carry_q && (hold_q == '1)) begin
                    err_d[ERR_CARRY_FF] = 1'b1;
                end
            end
        end
        if (evt_q && evt_skip_q) begin
            err_d[ERR_BP_SKIP] = 1'b1;
        end
        if (fifo_overflow) begin
            err_d[ERR_OVF] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (evt_q) begin
                    done_d  = 1'b0;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (flush_in) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                push       = hv_q;
                push_entry = '{last: 1'b1, data: hold_q};
                hv_d       = evt_q;
                if (evt_q) begin
                    hold_d = evt_byte_q;
                end
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A new byte during drain opens the next segment; the tagged byte still drains.
                if (evt_q) begin
                    state_d = ST_ACTIVE;
                end else if (fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bp_prev_q   <= '0;
            evt_q       <= 1'b0;
            evt_skip_q  <= 1'b0;
            evt_carry_q <= 1'b0;
            evt_byte_q  <= '0;
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hv_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
            byte_cnt_q  <= '0;
        end else begin
            bp_prev_q   <= bp_prev_d;
            evt_q       <= evt_d;
            evt_skip_q  <= evt_skip_d;
            evt_carry_q <= evt_carry_d;
            evt_byte_q  <= evt_byte_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            hv_q        <= hv_d;
            done_q      <= done_d;
            err_q       <= err_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

endmodule

// File: tb/tb_mq_byte_packer.sv
// Randomized self-checking bench for mq_byte_packer against a queue-based stream model.
module tb_mq_byte_packer;

    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] byte_in;
    logic [7:0]  bp_in;
    logic        flush_in;
    logic        almost_full;
    logic        done;
    logic [2:0]  err;
    logic [15:0] byte_cnt;

    mq_byte_packer_if bus ();

    mq_byte_packer #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .bp_in       (bp_in),
        .flush_in    (flush_in),
        .m_if        (bus),
        .almost_full (almost_full),
        .done        (done),
        .err         (err),
        .byte_cnt    (byte_cnt)
    );

    initial forever #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [8:0]  exp_q[$];
    logic [7:0]  mdl_h;
    bit          mdl_hv;
    logic [2:0]  exp_err;
    logic [15:0] exp_cnt;
    bit          rand_rdy;
    logic [8:0]  exp_item;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Model: each BP advance releases the previously held byte plus the new carry.
    task automatic ev(input logic [7:0] b, input logic c, input logic [7:0] step);
        bp_in   = bp_in + step;
        byte_in = {7'd0, c, b};
        if (step != 8'd1) exp_err[1] = 1'b1;
        if (mdl_hv) begin
            if (mdl_h == 8'hFF && c) exp_err[2] = 1'b1;
            if (exp_q.size() >= DEPTH) exp_err[0] = 1'b1;
            else exp_q.push_back({1'b0, 8'(mdl_h + {7'd0, c})});
        end
        mdl_h  = b;
        mdl_hv = 1'b1;
        tick();
    endtask

    task automatic flush_seg();
        flush_in = 1'b1;
        if (mdl_hv) begin
            if (exp_q.size() >= DEPTH) exp_err[0] = 1'b1;
            else exp_q.push_back({1'b1, mdl_h});
        end
        mdl_hv = 1'b0;
        tick();
        flush_in = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_cnt"}, byte_cnt, exp_cnt);
        chk({tag, "_err"}, err, exp_err);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            chk("stream_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_item = exp_q.pop_front();
                chk("stream_data", bus.m_data, exp_item[7:0]);
                chk("stream_last", bus.m_last, exp_item[8]);
                exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] cnt0;
        int          nev;
        rst = 1'b0; byte_in = '0; bp_in = '0; flush_in = 1'b0;
        bus.m_ready = 1'b0; rand_rdy = 1'b0;
        mdl_h = '0; mdl_hv = 1'b0; exp_err = '0; exp_cnt = '0;
        idle(2);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", byte_cnt, 0);
        chk("rst_af", almost_full, 0);
        rst = 1'b1;
        idle(2);

        // Basic sequence 0x12,0x34,0x56 with last on 0x56.
        bus.m_ready = 1'b1;
        ev(8'h12, 1'b0, 8'd1);
        ev(8'h34, 1'b0, 8'd1);
        ev(8'h56, 1'b0, 8'd1);
        idle(2);
        flush_seg();
        wait_done("seq");
        idle(3);
        chk("done_hold", done, 1);

        // Carry 0x7F -> 0x80.
        ev(8'h7F, 1'b0, 8'd1);
        idle(1);
        chk("done_clear", done, 0);
        ev(8'h00, 1'b1, 8'd1);
        idle(2);
        flush_seg();
        wait_done("carry");

        // Carry into 0xFF wraps and sets sticky err[2].
        ev(8'hFF, 1'b0, 8'd1);
        ev(8'h20, 1'b1, 8'd1);
        idle(2);
        flush_seg();
        wait_done("carry_ff");

        // BP skip.
        ev(8'h01, 1'b0, 8'd1);
        ev(8'h02, 1'b0, 8'd1);
        idle(2);
        chk("skip_before", err, exp_err);
        ev(8'h03, 1'b0, 8'd2);
        idle(2);
        chk("skip_flag", err, exp_err);
        ev(8'h04, 1'b0, 8'd1);
        ev(8'h05, 1'b0, 8'd1);
        idle(2);
        flush_seg();
        wait_done("skip");

        // Backpressure and overflow: 18 events into a stalled sink.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            ev(8'($urandom), 1'b0, 8'd1);
            idle(2);
            chk("ovf_af", almost_full, exp_q.size() >= AF_LEVEL);
        end
        chk("ovf_err", err, exp_err);
        chk("ovf_qlen", exp_q.size(), DEPTH);
        cnt0 = byte_cnt;
        bus.m_ready = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
        chk("ovf_drain_cnt", byte_cnt - cnt0, 16);
        idle(2);
        flush_seg();
        wait_done("ovf");

        // Randomized segments with random sink backpressure.
        rand_rdy = 1'b1;
        for (int s = 0; s < 8; s++) begin
            nev = $urandom_range(1, 8);
            for (int e = 0; e < nev; e++) begin
                ev(8'($urandom), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 9) == 0) ? 8'd2 : 8'd1);
                idle($urandom_range(0, 2));
            end
            idle(2);
            flush_seg();
            wait_done("rand");
        end
        rand_rdy = 1'b0;

        // Asynchronous reset while bytes are buffered in DRAIN.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) ev(8'(8'h40 + i), 1'b0, 8'd1);
        idle(2);
        flush_seg();
        idle(3);
        chk("ar_valid_before", bus.m_valid, 1);
        #3 rst = 1'b0;
        #1;
        chk("ar_valid", bus.m_valid, 0);
        chk("ar_done", done, 0);
        chk("ar_err", err, 0);
        chk("ar_cnt", byte_cnt, 0);
        exp_q.delete();
        mdl_hv = 1'b0; exp_err = '0; exp_cnt = '0;
        bp_in = '0; byte_in = '0;
        idle(2);
        rst = 1'b1;
        idle(2);
        bus.m_ready = 1'b1;
        ev(8'hA5, 1'b0, 8'd1);
        ev(8'h5A, 1'b0, 8'd1);
        idle(2);
        flush_seg();
        wait_done("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
